// File: rtl/sort4_ctrl.sv
// Sequential 4-element ascending sorter: bubble-sort passes with early exit,
// one compare/swap per clock through a single shared 4-bit comparator.

module comparator_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] r
);
  // r = {a>b, a==b, a<b}
  assign r = {a > b, a == b, a < b};
endmodule

module sort4_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done,
  output logic [2:0]  swaps
);
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   e [4];
  logic [1:0]          j, j_inc, last;
  logic                sw;
  logic [2:0]          swaps_q;
  logic [DATA_W-1:0]   cmp_a, cmp_b;
  logic [2:0]          cmp_r;
  logic                gt, pass_end, finish;

  comparator_4b u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .r (cmp_r)
  );

  // Pair selection and end-of-pass decisions for the current SORT cycle
  always_comb begin
    j_inc    = j + 2'd1;
    cmp_a    = e[j];
    cmp_b    = e[j_inc];
    gt       = cmp_r[2];
    pass_end = !(j < (last - 2'd1));
    // Early exit counts a swap made in this very cycle
    finish   = pass_end && (!(sw || gt) || (last == 2'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)  state_nx = SORT;
      SORT:    if (finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) e[i] <= '0;
      j       <= 2'd0;
      last    <= 2'd3;
      sw      <= 1'b0;
      swaps_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) e[i] <= din[4*i +: 4];
            j       <= 2'd0;
            last    <= 2'd3;
            sw      <= 1'b0;
            swaps_q <= 3'd0;
          end
        end
        SORT: begin
          if (gt) begin
            e[j]     <= cmp_b;
            e[j_inc] <= cmp_a;
            sw       <= 1'b1;
            swaps_q  <= swaps_q + 3'd1;
          end
          if (!pass_end) begin
            j <= j_inc;
          end else if (!finish) begin
            // Next pass is one pair shorter; its swap flag starts clear
            last <= last - 2'd1;
            j    <= 2'd0;
            sw   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = {e[3], e[2], e[1], e[0]};
  assign swaps = swaps_q;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule
